// File: rtl/mem_req_responder.sv
// Serializes icache/dcache requests onto a single-ported backing memory over a
// valid/ready request channel; data op first, then instruction fetch.
module mem_req_responder #(
  parameter int          RESP_TIMEOUT = 255,
  parameter logic [31:0] ERR_DATA     = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] icache_addr,
  input  logic        icache_re,
  output logic [31:0] icache_dout,
  input  logic [31:0] dcache_addr,
  input  logic        dcache_re,
  input  logic [3:0]  dcache_we,
  input  logic [31:0] dcache_din,
  output logic [31:0] dcache_dout,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_rnw,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  output logic [3:0]  mem_req_mask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        mem_err
);

  typedef enum logic [2:0] {IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT} state_t;

  localparam bit          TO_EN   = (RESP_TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = 16'(RESP_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_stall;
  logic        r_req_valid;
  logic        r_req_rnw;
  logic [31:0] r_req_addr;
  logic [31:0] r_req_data;
  logic [3:0]  r_req_mask;
  logic        r_i_pend;
  logic [29:0] r_i_addr;
  logic [15:0] r_wd_cnt;
  logic [31:0] r_idout;
  logic [31:0] r_ddout;
  logic        r_err;

  logic        w_d_op;
  logic        w_capture;
  logic        w_hs;
  logic        w_in_wait;
  logic        w_timeout;
  logic        w_done;
  logic [31:0] w_rdata;
  logic [29:0] w_i_word;
  logic        w_unused_addr_bits;

  assign w_d_op    = dcache_re | (|dcache_we);
  assign w_capture = (r_state == IDLE) & (icache_re | w_d_op);
  assign w_hs      = r_req_valid & mem_req_ready;
  assign w_in_wait = (r_state == D_WAIT) | (r_state == I_WAIT);
  assign w_timeout = TO_EN & (r_wd_cnt == TO_LAST) & ~mem_resp_valid;
  assign w_done    = mem_resp_valid | w_timeout;
  assign w_rdata   = mem_resp_valid ? mem_resp_data : ERR_DATA;
  // Fetch straight from the port when no data op went first.
  assign w_i_word  = (r_state == IDLE) ? icache_addr[31:2] : r_i_addr;
  assign w_unused_addr_bits = ^{icache_addr[1:0], dcache_addr[1:0]};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_capture) w_state_next = w_d_op ? D_REQ : I_REQ;
      D_REQ:   if (w_hs) w_state_next = r_req_rnw ? D_WAIT : (r_i_pend ? I_REQ : IDLE);
      I_REQ:   if (w_hs) w_state_next = I_WAIT;
      D_WAIT:  if (w_done) w_state_next = r_i_pend ? I_REQ : IDLE;
      I_WAIT:  if (w_done) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_stall     <= 1'b0;
      r_req_valid <= 1'b0;
      r_req_rnw   <= 1'b0;
      r_req_addr  <= '0;
      r_req_data  <= '0;
      r_req_mask  <= '0;
      r_i_pend    <= 1'b0;
      r_i_addr    <= '0;
      r_wd_cnt    <= '0;
      r_idout     <= '0;
      r_ddout     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_stall     <= (w_state_next != IDLE);
      r_req_valid <= (w_state_next == D_REQ) | (w_state_next == I_REQ);
      if (w_capture) begin
        r_i_pend <= icache_re;
        r_i_addr <= icache_addr[31:2];
      end
      // Payload loads only when a REQ state is entered, so it is frozen until handshake.
      if (w_capture && w_d_op) begin
        r_req_rnw  <= ~(|dcache_we);
        r_req_addr <= {dcache_addr[31:2], 2'b00};
        r_req_mask <= dcache_we;
        r_req_data <= dcache_din;
      end else if ((w_state_next == I_REQ) && (r_state != I_REQ)) begin
        r_req_rnw  <= 1'b1;
        r_req_addr <= {w_i_word, 2'b00};
        r_req_mask <= 4'b0000;
      end
      r_wd_cnt <= w_in_wait ? r_wd_cnt + 16'd1 : 16'd0;
      if ((r_state == D_WAIT) && w_done) r_ddout <= w_rdata;
      if ((r_state == I_WAIT) && w_done) r_idout <= w_rdata;
      if (w_in_wait && w_timeout) r_err <= 1'b1;
    end
  end

  assign stall         = r_stall;
  assign mem_req_valid = r_req_valid;
  assign mem_req_rnw   = r_req_rnw;
  assign mem_req_addr  = r_req_addr;
  assign mem_req_data  = r_req_data;
  assign mem_req_mask  = r_req_mask;
  assign icache_dout   = r_idout;
  assign dcache_dout   = r_ddout;
  assign mem_err       = r_err;

endmodule
